ps2_host_cmd_ctrl: RTL and testbench
====================================

Name: ps2_host_cmd_ctrl

Overview:
- Host-to-keyboard command controller for the PS/2 port; sits beside the PS/2 receive path and shares the same two open-drain lines with it.
- Sequences one command byte: line inhibit, request-to-send, bit-serial transmit, device ack-bit check, then waits for the device's 0xFA/0xFE response from the receive path.
- Retries on 0xFE and reports one status per command.
- Holds the receiver in flush while the host owns the bus, so host frames are never decoded as keystrokes.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- INHIBIT_US, 100, clock-low inhibit time before request-to-send. INHIBIT_CYC = CLK_HZ/1000000*INHIBIT_US.
- TIMEOUT_US, 15000, maximum gap between device clock edges or before a response. TIMEOUT_CYC is derived the same way as INHIBIT_CYC.
- MAX_RETRY, 3, resends allowed after receiving 0xFE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_byte  in  8  command/data byte to send.
- cmd_ready  out  1  controller idle and able to accept a command.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release it.
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release it.
- rx_byte  in  8  scan code from the receive path.
- rx_valid  in  1  1-cycle strobe marking a valid received frame.
- rx_hold  out  1  1 = receiver must flush its shift register and bit count.
- resp_valid  out  1  1-cycle status pulse.
- resp_code  out  2  00 ACK, 01 RESEND_EXHAUSTED, 10 TIMEOUT, 11 NO_ACK_BIT.

Behaviour:
- Reset: synchronous and active-high. Clock port is clk, reset port is rst; one clock domain. On rst, go to IDLE with cmd_ready=1, all oe=0, rx_hold=0, resp_valid=0, resp_code=00, and counters cleared.
- Reset mid-transfer releases both lines on the next clk edge. No status is reported for the aborted command.
- Pin synchronizers: 2-flop, reset to 1. A falling edge is detected as synced-previous=1 and synced-current=0.
- IDLE: cmd_ready=1. When cmd_valid=1 in a cycle with cmd_ready=1:
  - latch cmd_byte;
  - compute parity = ~^cmd_byte (odd parity);
  - clear retry_cnt;
  - go to INHIBIT. cmd_ready is 0 from the next cycle.
  - cmd_valid while not ready is ignored.
- INHIBIT: clk_oe=1, data_oe=0, rx_hold=1 for INHIBIT_CYC cycles, then REQ.
- REQ: clk_oe=1, data_oe=1 for exactly 1 cycle (this is the start bit), then SEND.
- SEND: clk_oe=0; rx_hold=1; frame vector = {1, parity, byte[7:0]}.
  - Falling edge n (n=1..10) presents vector bit n-1. data_oe = ~bit, so the stop bit releases the line.
  - Falling edge 11 goes to ACK_BIT.
- ACK_BIT: all oe=0. Sample synced data on the 11th edge: 0 = ack; 1 = finish with NO_ACK_BIT.
  - After an ack, wait until synced clk and synced data are both 1, then go to WAIT_RESP.
- WAIT_RESP: rx_hold=0; wait for rx_valid.
  - rx_byte 0xFA -> finish with ACK.
  - rx_byte 0xFE: if retry_cnt<MAX_RETRY, increment retry_cnt and go to INHIBIT with the same byte; otherwise finish with RESEND_EXHAUSTED.
  - Any other byte is ignored and the controller keeps waiting.
- Timer: cleared on every state entry and on every falling edge.
  - In SEND, ACK_BIT or WAIT_RESP, reaching TIMEOUT_CYC finishes with TIMEOUT.
  - Lines are released in the same cycle the timeout is detected.
- Finish: resp_valid=1 and resp_code are valid for exactly 1 cycle. The state returns to IDLE in that same cycle, so cmd_ready=1 on the next cycle.
- A falling edge seen in IDLE is ignored (the device is transmitting to the receiver).

Optional Feature:
- Macro PS2_LED_SEQ_EN.
- Defined: adds ports led_req (in, 1) and led_bits (in, 3: scroll, num, caps).
  - In IDLE, cmd_valid has priority over led_req.
  - An accepted led_req sends 0xED. After its ACK, the controller automatically sends {5'b0, led_bits as latched at acceptance}.
  - A single resp_valid is issued after the second byte's ACK. If the first byte fails, that byte's failure code is reported and the sequence stops.
  - cmd_ready stays 0 for the whole sequence.
- Undefined: the ports are absent and only single-byte commands exist.

Test Plan:
- Device model clocks out ack 0 then replies 0xFA, cmd_byte=0xF4:
  - data_oe pattern over edges 1..10 = ~{0,0,1,0,1,1,1,1,0(parity),1};
  - then resp_valid=1 with resp_code=00;
  - cmd_ready returns to 1 on the next cycle.
- Device replies 0xFE four times, MAX_RETRY=3: exactly 4 transmissions are observed, then resp_code=01.
- Device never clocks after REQ: resp_code=10 at TIMEOUT_CYC after REQ exit, with clk_oe=data_oe=0.
- Device leaves data high on edge 11: resp_code=11, and no wait for a response.
- rst asserted mid-SEND after edge 5: next cycle oe=0, cmd_ready=1, resp_valid never pulses. A new cmd_valid with 0xED then completes normally.
- PS2_LED_SEQ_EN defined, led_req with led_bits=3'b101: sends 0xED then 0x05, one resp_valid with code 00. A concurrent cmd_valid in IDLE is served first.

Source files
------------

// File: rtl/ps2_host_cmd_ctrl.sv
// ps2_host_cmd_ctrl
// Host-to-device command sequencer for a PS/2 port. Sends one command byte
// (inhibit, request-to-send, 11-bit serial transmit, ack-bit check), then
// waits for the device's 0xFA/0xFE reply from the receive path. Resends on
// 0xFE up to MAX_RETRY times and reports one status per command.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cmd_valid/_byte   command request and byte; accepted when cmd_ready=1
//   cmd_ready         idle, able to accept a command
//   ps2_clk_in/_data_in   raw pin levels (asynchronous)
//   ps2_clk_oe/_data_oe   1 = pull the line low, 0 = release
//   rx_byte/rx_valid  frame from the receive path
//   rx_hold           receiver flush while the host owns the bus
//   resp_valid/_code  1-cycle status: 00 ACK, 01 RESEND_EXHAUSTED,
//                     10 TIMEOUT, 11 NO_ACK_BIT
//
// Optional build macro PS2_LED_SEQ_EN adds led_req/led_bits: an accepted
// led_req sends 0xED followed by {5'b0, led_bits} with a single status.
// INHIBIT_CYC must be at least 4 so the self-inflicted clock fall from the
// inhibit has cleared the synchronizers before SEND starts.
module ps2_host_cmd_ctrl #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_hold,
  output logic       resp_valid,
  output logic [1:0] resp_code
`ifdef PS2_LED_SEQ_EN
  ,
  input  logic       led_req,
  input  logic [2:0] led_bits
`endif
);

  localparam int unsigned INHIBIT_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TMAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TMO_CYC  = TW'(TIMEOUT_CYC);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK_BIT   = 3'd4;
  localparam logic [2:0] S_WAIT_RESP = 3'd5;

  localparam logic [1:0] RC_ACK     = 2'b00;
  localparam logic [1:0] RC_RESEND  = 2'b01;
  localparam logic [1:0] RC_TIMEOUT = 2'b10;
  localparam logic [1:0] RC_NO_ACK  = 2'b11;

  logic          clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
  logic [2:0]    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fall, timed, timeout, fin;
  logic [1:0]    code;
  logic [9:0]    frame;
`ifdef PS2_LED_SEQ_EN
  logic          seq_q, seq_d;
  logic [2:0]    led_q, led_d;
`endif

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timed   = (state_q == S_SEND) || (state_q == S_ACK_BIT) || (state_q == S_WAIT_RESP);
  assign timeout = timed && (timer_q == TMO_CYC);
  assign frame   = {1'b1, parity_q, byte_q};

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    retry_d   = retry_q;
    bit_cnt_d = bit_cnt_q;
    fin       = 1'b0;
    code      = RC_ACK;
`ifdef PS2_LED_SEQ_EN
    seq_d     = seq_q;
    led_d     = led_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          byte_d   = cmd_byte;
          parity_d = ~^cmd_byte;
          retry_d  = '0;
          state_d  = S_INHIBIT;
        end
`ifdef PS2_LED_SEQ_EN
        else if (led_req) begin
          byte_d   = 8'hED;
          parity_d = ~^8'hED;
          retry_d  = '0;
          led_d    = led_bits;
          seq_d    = 1'b1;
          state_d  = S_INHIBIT;
        end
`endif
      end
      S_INHIBIT: if (timer_q == INH_LAST) state_d = S_REQ;
      S_REQ: begin
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          // Edge 11 carries the device's ack bit; earlier edges advance the frame.
          if (bit_cnt_q == 4'd10) begin
            if (data_s2_q) begin
              fin  = 1'b1;
              code = RC_NO_ACK;
            end else begin
              state_d = S_ACK_BIT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout) begin
          fin  = 1'b1;
          code = RC_TIMEOUT;
        end
      end
      S_ACK_BIT: begin
        if (clk_s2_q && data_s2_q) begin
          state_d = S_WAIT_RESP;
        end else if (timeout) begin
          fin  = 1'b1;
          code = RC_TIMEOUT;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid && rx_byte == 8'hFA) begin
`ifdef PS2_LED_SEQ_EN
          if (seq_q) begin
            seq_d    = 1'b0;
            byte_d   = {5'b0, led_q};
            parity_d = ~^{5'b0, led_q};
            retry_d  = '0;
            state_d  = S_INHIBIT;
          end else begin
            fin = 1'b1;
          end
`else
          fin = 1'b1;
`endif
        end else if (rx_valid && rx_byte == 8'hFE) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_INHIBIT;
          end else begin
            fin  = 1'b1;
            code = RC_RESEND;
          end
        end else if (timeout) begin
          fin  = 1'b1;
          code = RC_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_IDLE;
`ifdef PS2_LED_SEQ_EN
      seq_d   = 1'b0;
`endif
    end
    // Falls only restart the timer while the device is expected to clock; the
    // host's own inhibit pulls the pin low and must not stretch the inhibit.
    if ((state_d != state_q) || (fall && timed)) timer_d = '0;
    else                                         timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      state_q    <= S_IDLE;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      retry_q    <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
      state_q    <= state_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      retry_q    <= retry_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
    end
  end

`ifdef PS2_LED_SEQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= 1'b0;
      led_q <= '0;
    end else begin
      seq_q <= seq_d;
      led_q <= led_d;
    end
  end
`endif

  // Before edge 1 the start bit (low) stays driven; lines drop on finish.
  always_comb begin
    ps2_data_oe = 1'b0;
    if (state_q == S_REQ) ps2_data_oe = 1'b1;
    else if (state_q == S_SEND && !fin)
      ps2_data_oe = (bit_cnt_q == 4'd0) ? 1'b1 : ~frame[bit_cnt_q - 4'd1];
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign rx_hold    = (state_q == S_INHIBIT) || (state_q == S_REQ) ||
                      (state_q == S_SEND) || (state_q == S_ACK_BIT);
  assign resp_valid = fin;
  assign resp_code  = fin ? code : 2'b00;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_host_cmd_ctrl;
  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned INHIBIT_US = 5;
  localparam int unsigned TIMEOUT_US = 300;
  localparam int unsigned MAX_RETRY = 3;
  localparam int I_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int T_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int H = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic cmd_ready, ps2_clk_oe, ps2_data_oe, rx_hold, resp_valid;
  logic [1:0] resp_code;
  logic [7:0] rx_byte = '0;
  logic rx_valid = 1'b0;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in;
`ifdef PS2_LED_SEQ_EN
  logic led_req = 1'b0;
  logic [2:0] led_bits = '0;
`endif

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, want_lat = -1;
  bit m_busy = 1'b0;
  logic [1:0] exp_q[$];

  ps2_host_cmd_ctrl #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US),
                      .TIMEOUT_US(TIMEOUT_US), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_hold(rx_hold), .resp_valid(resp_valid),
    .resp_code(resp_code)
`ifdef PS2_LED_SEQ_EN
    , .led_req(led_req), .led_bits(led_bits)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  // Wire order of a host frame: data bits LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle check against the transaction-level model: one status per
  // command with the predicted code, ready only while no command is open.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmd_ready", cmd_ready, !m_busy);
      if (!m_busy) chk("idle_lines", {ps2_clk_oe, ps2_data_oe, rx_hold}, 3'b000);
      if (resp_valid) begin
        chk("resp_expected", m_busy, 1);
        if (exp_q.size() > 0) chk("resp_code", resp_code, exp_q.pop_front());
        chk("resp_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        if (want_lat >= 0) begin
          chk("timeout_latency", cyc - acc_cyc, want_lat);
          want_lat = -1;
        end
        m_busy = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b, input logic [1:0] code);
    tick;
    cmd_valid = 1'b1;
    cmd_byte  = b;
    acc_cyc   = cyc;
    tick;
    m_busy = 1'b1;
    exp_q.push_back(code);
    cmd_valid = 1'b0;
  endtask

  // Device side of a host->device frame: waits for the start bit, clocks
  // n_edges falling edges and reads the data pin just before each rise.
  task automatic dev_frame(input bit give_ack, input int n_edges,
                           output logic [9:0] got, output bit ok);
    int n = 0;
    got = '0;
    while (!(ps2_clk_in && !ps2_data_in) && n < 200) begin tick; n++; end
    chk("dev_start_seen", {ps2_clk_in, ps2_data_in}, 2'b10);
    ok = (n < 200);
    if (ok) begin
      repeat (4) tick;
      for (int e = 1; e <= n_edges; e++) begin
        if (e == 11 && give_ack) begin
          dev_data = 1'b0;
          repeat (3) tick;
        end
        dev_clk = 1'b0;
        repeat (H) tick;
        if (e <= 10) got[e-1] = ps2_data_in;
        if (e == 5) chk("rx_hold_in_frame", rx_hold, 1);
        dev_clk = 1'b1;
        repeat (H) tick;
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic dev_reply(input logic [7:0] b);
    int n = 0;
    while (rx_hold && n < 100) begin tick; n++; end
    chk("rx_hold_released", rx_hold, 0);
    repeat (3) tick;
    rx_byte  = b;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin tick; n++; end
    chk("status_reported", m_busy, 0);
  endtask

  initial begin
    logic [9:0] got;
    bit ok;
    int tx;

    repeat (3) tick;
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_rx_hold", rx_hold, 0);
    chk("rst_resp", {resp_valid, resp_code}, 3'b000);

    // 0xF4 with ack; an unrelated byte is ignored before 0xFA.
    send_cmd(8'hF4, 2'b00);
    dev_frame(1'b1, 11, got, ok);
    chk("frame_F4_model", got, frame_of(8'hF4));
    chk("frame_F4_literal", got, 10'h2F4);
    dev_reply(8'hAA);
    chk("still_busy_after_AA", cmd_ready, 0);
    dev_reply(8'hFA);
    wait_done(20);

    // Four 0xFE replies: original plus three resends, then exhausted.
    send_cmd(8'h20, 2'b01);
    tx = 0;
    while (m_busy && tx < 6) begin
      dev_frame(1'b1, 11, got, ok);
      if (!ok) break;
      tx++;
      chk("frame_retry", got, frame_of(8'h20));
      dev_reply(8'hFE);
    end
    chk("retry_tx_count", tx, 4);
    wait_done(20);

    // Device never clocks: status at TIMEOUT_CYC after leaving REQ.
    want_lat = I_CYC + T_CYC + 2;
    send_cmd(8'h55, 2'b10);
    wait_done(I_CYC + T_CYC + 60);

    // Data left high on edge 11: immediate NO_ACK_BIT, no reply needed.
    send_cmd(8'hFF, 2'b11);
    dev_frame(1'b0, 11, got, ok);
    chk("frame_FF_model", got, frame_of(8'hFF));
    wait_done(40);

    // Reset after edge 5 aborts silently; next command runs normally.
    send_cmd(8'h3C, 2'b00);
    dev_frame(1'b1, 5, got, ok);
    tick;
    rst = 1'b1;
    m_busy = 1'b0;
    exp_q.delete();
    tick;
    rst = 1'b0;
    chk("abort_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("abort_ready", cmd_ready, 1);
    repeat (30) tick;
    send_cmd(8'hED, 2'b00);
    dev_frame(1'b1, 11, got, ok);
    chk("frame_ED_literal", got, 10'h3ED);
    dev_reply(8'hFA);
    wait_done(20);

`ifdef PS2_LED_SEQ_EN
    // cmd_valid wins over a concurrent led_req; LED bits latched at acceptance.
    tick;
    cmd_valid = 1'b1;
    cmd_byte  = 8'hF4;
    led_req   = 1'b1;
    led_bits  = 3'b101;
    tick;
    m_busy = 1'b1;
    exp_q.push_back(2'b00);
    cmd_valid = 1'b0;
    dev_frame(1'b1, 11, got, ok);
    chk("led_first_cmd", got, 10'h2F4);
    dev_reply(8'hFA);
    wait_done(20);
    tick;
    m_busy = 1'b1;
    exp_q.push_back(2'b00);
    led_req  = 1'b0;
    led_bits = 3'b000;
    dev_frame(1'b1, 11, got, ok);
    chk("led_ED", got, 10'h3ED);
    dev_reply(8'hFA);
    dev_frame(1'b1, 11, got, ok);
    chk("led_bits_frame", got, 10'h305);
    dev_reply(8'hFA);
    wait_done(20);
`endif

    repeat (10) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
